alu_arbiter: RTL

//  Shares one combinational 32-bit ALU (3-bit control, A/B operands, out + Zero) between two

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands toward the ALU and a registered response.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  state_t next_s;
  logic   last_grant_r;
  logic   winner_s;
  logic   accept_s;
  logic   rsp_done_s;

  // Flags the undefined ALU control codes 110 and 111.
  function automatic logic is_illegal(input logic [OPW-1:0] op);
    return (op == OPW'(3'b110)) || (op == OPW'(3'b111));
  endfunction

  // Round-robin winner selection, request acceptance and next-state decode.
  always_comb begin
    next_s     = state_r;
    req_ready  = 2'b00;
    winner_s   = 1'b0;
    accept_s   = 1'b0;
    rsp_done_s = 1'b0;
    case (req_valid)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~last_grant_r;
      default: winner_s = 1'b0;
    endcase
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          req_ready[winner_s] = 1'b1;
          accept_s            = 1'b1;
          next_s              = EXEC;
        end else begin
          next_s = IDLE;
        end
      end
      EXEC: next_s = RESP;
      RESP: begin
        // Only the granted requester's ready bit can retire the response.
        if (rsp_ready[last_grant_r]) begin
          rsp_done_s = 1'b1;
          next_s     = IDLE;
        end else begin
          next_s = RESP;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Operand latch, result capture, response valid and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      alu_a        <= {WIDTH{1'b0}};
      alu_b        <= {WIDTH{1'b0}};
      alu_control  <= {OPW{1'b0}};
      rsp_result   <= {WIDTH{1'b0}};
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_valid    <= 2'b00;
      busy         <= 1'b0;
    end else begin
      busy <= (next_s != IDLE);
      if (accept_s) begin
        last_grant_r <= winner_s;
        alu_a        <= winner_s ? req_a1  : req_a0;
        alu_b        <= winner_s ? req_b1  : req_b0;
        alu_control  <= winner_s ? req_op1 : req_op0;
      end
      if (state_r == EXEC) begin
        // The ALU output is undefined for illegal codes, so force a clean zero result.
        if (is_illegal(alu_control)) begin
          rsp_result <= {WIDTH{1'b0}};
          rsp_zero   <= 1'b1;
          rsp_err    <= 1'b1;
        end else begin
          rsp_result <= alu_out;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
        rsp_valid <= last_grant_r ? 2'b10 : 2'b01;
      end else if (rsp_done_s) begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule
